bcd_to_bin: RTL and testbench
=============================

BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 Parameter DIGITS, default 8: number of packed BCD digits at the input.
REQ-002 Parameter BW, default 27: binary result width; SHALL satisfy 2^BW > 10^DIGITS - 1 (27 for 8 digits).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_bcd holds a value to convert.
REQ-006 in_bcd  input  4*DIGITS  packed BCD, digit 0 in bits [3:0].
REQ-007 in_ready  output  1  block accepts a new value.
REQ-008 out_valid  output  1  out_bin/out_err hold a result.
REQ-009 out_bin  output  BW  binary value of the accepted BCD word.
REQ-010 out_err  output  1  accepted word contained a digit >9 (REQ-027).
REQ-011 out_ready  input  1  consumer takes the result.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; in_ready SHALL equal (state==IDLE), combinationally.
REQ-013 Accept on a clk edge with state IDLE and in_valid=1: load working register {bcd=in_bcd, bin=0}, clear iteration counter, go to SHIFT.
REQ-014 Each SHIFT cycle performs one reverse double-dabble iteration: shift {bcd,bin} right 1 bit (bcd LSB enters bin MSB), then subtract 3 from every bcd digit whose shifted value is >=8.
REQ-015 SHIFT runs exactly BW iterations; on the edge completing iteration BW, go to DONE with out_valid=1 and out_bin = bin.
REQ-016 Latency: out_valid rises BW clk edges after the accept edge (27 for defaults); throughput one word per BW+2 cycles minimum.
REQ-017 in_valid and in_bcd are ignored outside IDLE; in_bcd is sampled only on the accept edge.
REQ-018 DONE: out_valid, out_bin and out_err SHALL hold stable until an edge with out_ready=1, then go to IDLE with out_valid=0.
REQ-019 out_ready=1 while out_valid=0 has no effect.
REQ-020 A new word is never accepted on the same edge a result is retired; in_ready rises the cycle after.
REQ-021 out_bin SHALL be correct for every valid input 0..10^DIGITS-1; no arithmetic saturation or wrap occurs.
REQ-022 out_bin and out_err SHALL keep their last value while in IDLE/SHIFT; only out_valid qualifies them.

Reset
REQ-023 rst=1 on any edge, including mid-SHIFT or in DONE, SHALL force IDLE and abort any conversion.
REQ-024 Reset values: out_valid=0, out_bin=0, out_err=0, iteration counter 0, working register 0; in_ready=1 the cycle after reset releases.
REQ-025 rst has priority over accept and retire on the same edge.

Configuration
REQ-026 Macro BCD_TO_BIN_CHECK_EN selects invalid-digit checking.
REQ-027 With BCD_TO_BIN_CHECK_EN defined: on accept, if any digit of in_bcd is >9, skip SHIFT and enter DONE on the next edge with out_err=1, out_bin=0; valid words give out_err=0.
REQ-028 Without BCD_TO_BIN_CHECK_EN: out_err tied 0, no digit check logic, every word runs the full BW iterations (result for invalid digits unspecified but deterministic).

Verification
REQ-029 Accept in_bcd=32'h12345678, out_ready=1 -> out_valid after 27 edges, out_bin=27'h0BC614E, out_err=0.
REQ-030 in_bcd=32'h99999999 -> out_bin=27'h5F5E0FF; in_bcd=32'h00000000 -> out_bin=0; both latency 27.
REQ-031 in_bcd=32'h00000042, out_ready=0 for 10 cycles after out_valid -> out_bin=27'd42 held stable, in_ready=0 throughout; retire on out_ready=1, in_ready=1 next cycle.
REQ-032 Accept 32'h12345678, assert rst at iteration 10 -> out_valid=0, out_bin=0, in_ready=1 after release; then 32'h00000007 converts to 7.
REQ-033 With BCD_TO_BIN_CHECK_EN: in_bcd=32'h1234567A -> out_valid one edge after accept, out_err=1, out_bin=0; without macro, same stimulus -> out_valid after 27 edges, out_err=0.
REQ-034 Back-to-back: in_valid held high with 32'h00000001 then 32'h00000010 -> results 1 then 10, second accepted one cycle after first retired.

Source files
------------

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential packed-BCD to binary converter.
// Uses reverse double-dabble: one shift/correct iteration per clock, BW
// iterations per word, with a valid/ready handshake on both sides.
// Optional build macro: BCD_TO_BIN_CHECK_EN enables invalid-digit (>9)
// detection. With it, a bad word skips the iterations and returns out_err=1,
// out_bin=0. Without it, out_err is tied low and no check logic is built.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for in_valid; in_ready is high only here
//   SHIFT | running reverse double-dabble iterations on the working register
//   DONE  | result presented on out_valid/out_bin/out_err until out_ready

module bcd_to_bin #(
    parameter int DIGITS = 8,
    parameter int BW     = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [BW-1:0]         out_bin,
    output logic                  out_err,
    input  logic                  out_ready
);

    localparam int BCDW = 4 * DIGITS;
    localparam int CW   = $clog2(BW + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(BW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   iter_cnt;
    logic [BCDW-1:0] work_bcd;
    logic [BW-1:0]   work_bin;

    logic [BCDW-1:0] shifted_bcd;
    logic [BCDW-1:0] next_bcd;
    logic [BW-1:0]   next_bin;

    // Upstream handshake: a new word can only be taken while idle.
    assign in_ready = (state == IDLE);

    // One reverse double-dabble step: shift {bcd,bin} right, then pull every
    // digit that landed at >=8 back down by 3 so it stays a legal decimal digit.
    always_comb begin
        shifted_bcd = work_bcd >> 1;
        next_bin    = {work_bcd[0], work_bin[BW-1:1]};
        next_bcd    = shifted_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted_bcd[4*i +: 4] >= 4'd8) begin
                next_bcd[4*i +: 4] = shifted_bcd[4*i +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_TO_BIN_CHECK_EN
    logic bad_digit_in;
    logic bad_word;

    // Flag any nibble of the incoming word that is not a decimal digit.
    always_comb begin
        bad_digit_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (in_bcd[4*i +: 4] > 4'd9) begin
                bad_digit_in = 1'b1;
            end
        end
    end

    // Control FSM with digit check; a bad word spends a single cycle in SHIFT
    // and then reports the error instead of iterating.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            iter_cnt  <= '0;
            work_bcd  <= '0;
            work_bin  <= '0;
            bad_word  <= 1'b0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work_bcd <= in_bcd;
                        work_bin <= '0;
                        iter_cnt <= '0;
                        bad_word <= bad_digit_in;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bad_word) begin
                        out_valid <= 1'b1;
                        out_bin   <= '0;
                        out_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        work_bcd <= next_bcd;
                        work_bin <= next_bin;
                        iter_cnt <= iter_cnt + 1'b1;
                        if (iter_cnt == LAST_ITER) begin
                            out_valid <= 1'b1;
                            out_bin   <= next_bin;
                            out_err   <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
`else
    assign out_err = 1'b0;

    // Control FSM: every accepted word runs the full BW iterations.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            iter_cnt  <= '0;
            work_bcd  <= '0;
            work_bin  <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work_bcd <= in_bcd;
                        work_bin <= '0;
                        iter_cnt <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_bcd <= next_bcd;
                    work_bin <= next_bin;
                    iter_cnt <= iter_cnt + 1'b1;
                    if (iter_cnt == LAST_ITER) begin
                        out_valid <= 1'b1;
                        out_bin   <= next_bin;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: self-checking bench for bcd_to_bin (default DIGITS=8, BW=27).
// Expected results come from a decimal-arithmetic model of the BCD word.

module tb_bcd_to_bin;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_bcd;
    logic        in_ready;
    logic        out_valid;
    logic [26:0] out_bin;
    logic        out_err;
    logic        out_ready;

    int n_vec;
    int n_mis;

    logic [31:0] last_bin;
    bit          last_known;

    bcd_to_bin dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_bcd   (in_bcd),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_bin  (out_bin),
        .out_err  (out_err),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, obs, obs, exp_v, exp_v);
        end
    endtask

    // Decimal value of a packed BCD word, most significant digit first.
    function automatic logic [31:0] bcd_value(input logic [31:0] b);
        logic [31:0] v;
        v = 0;
        for (int i = 7; i >= 0; i--) v = v * 10 + 32'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [31:0] rand_bcd();
        logic [31:0] b;
        b = 0;
        for (int i = 0; i < 8; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
        return b;
    endfunction

    // Waits for out_valid, returning the number of edges seen after the accept edge.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_word(input logic [31:0] bcd, input int stall,
                            input logic [31:0] exp_bin, input logic exp_err,
                            input int exp_lat, input bit bin_known);
        int lat;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_bcd    = bcd;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bcd   = $urandom;
        check("in_ready_busy", in_ready, 0);
        if (last_known) check("bin_hold_shift", out_bin, last_bin);
        wait_result(lat);
        check("latency", lat, exp_lat);
        check("out_err", out_err, exp_err);
        if (bin_known) check("out_bin", out_bin, exp_bin);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            if (bin_known) check("hold_bin", out_bin, exp_bin);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("retired_valid", out_valid, 0);
        check("retired_in_ready", in_ready, 1);
        out_ready  = 1'b0;
        last_known = bin_known;
        last_bin   = exp_bin;
    endtask

    initial begin
        int          lat;
        logic [31:0] w;
        n_vec      = 0;
        n_mis      = 0;
        last_known = 1'b0;
        last_bin   = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_bcd     = 0;
        out_ready  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bin", out_bin, 0);
        check("rst_out_err", out_err, 0);
        check("rst_in_ready", in_ready, 1);
        last_known = 1'b1;

        // Directed words, including a held result with out_ready low.
        run_word(32'h12345678, 0, 32'h0BC614E, 1'b0, 27, 1'b1);
        run_word(32'h99999999, 0, 32'h5F5E0FF, 1'b0, 27, 1'b1);
        run_word(32'h00000000, 0, 32'h0,       1'b0, 27, 1'b1);
        run_word(32'h00000042, 10, 32'd42,     1'b0, 27, 1'b1);

        // Reset in the middle of a conversion.
        @(negedge clk);
        in_valid = 1'b1;
        in_bcd   = 32'h12345678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_out_bin", out_bin, 0);
        check("abort_in_ready", in_ready, 1);
        last_known = 1'b1;
        last_bin   = 0;
        run_word(32'h00000007, 0, 32'd7, 1'b0, 27, 1'b1);

        // Invalid digit handling depends on the build.
`ifdef BCD_TO_BIN_CHECK_EN
        run_word(32'h1234567A, 1, 32'h0, 1'b1, 1, 1'b1);
`else
        run_word(32'h1234567A, 1, 32'h0, 1'b0, 27, 1'b0);
`endif

        // Back-to-back with in_valid held high.
        @(negedge clk);
        in_valid  = 1'b1;
        in_bcd    = 32'h00000001;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("b2b_accept1", in_ready, 0);
        in_bcd = 32'h00000010;
        wait_result(lat);
        check("b2b_lat1", lat, 27);
        check("b2b_bin1", out_bin, 1);
        @(posedge clk); #1;
        check("b2b_retire_valid", out_valid, 0);
        check("b2b_retire_ready", in_ready, 1);
        @(posedge clk); #1;
        check("b2b_accept2", in_ready, 0);
        wait_result(lat);
        check("b2b_lat2", lat, 27);
        check("b2b_bin2", out_bin, 10);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_retire2", out_valid, 0);
        out_ready  = 1'b0;
        last_known = 1'b1;
        last_bin   = 10;

        // Randomised valid words with random consumer stalls.
        for (int k = 0; k < 20; k++) begin
            w = rand_bcd();
            run_word(w, $urandom_range(0, 3), bcd_value(w), 1'b0, 27, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
